// File: rtl/wts_arb_pkg.sv
// Shared types and constants for the wavetable SRAM arbiter.
// The guard counter width only exists when WTS_ARB_HOST_GUARD_EN is defined.
package wts_arb_pkg;
    localparam int ADDR_W              = 11;
    localparam int RAM_SIZE            = 2048;
    localparam int DATA_W              = 8;
    localparam int GUARD_LIMIT_DEFAULT = 3;
`ifdef WTS_ARB_HOST_GUARD_EN
    localparam int GUARD_W             = 8;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        HOST,
        MIX
    } req_tag_t;

    function automatic logic [ADDR_W-1:0] ram_addr(input logic bank,
                                                   input logic [2:0] id,
                                                   input logic [6:0] a);
        return {bank, id, a};
    endfunction
endpackage

// File: rtl/wts_sram_arbiter_if.sv
// Host and mixer request/response bus plus clear control for the SRAM arbiter.
// The slave modport is the arbiter side, master is the requester side.
interface wts_sram_arbiter_if;
    import wts_arb_pkg::*;

    logic              host_req;
    logic              host_we;
    logic              host_bank;
    logic [2:0]        host_id;
    logic [6:0]        host_a;
    logic [DATA_W-1:0] host_d;
    logic              host_ack;
    logic [DATA_W-1:0] host_q;
    logic              host_q_valid;

    logic              mix_req;
    logic              mix_bank;
    logic [2:0]        mix_id;
    logic [6:0]        mix_a;
    logic              mix_ack;
    logic [DATA_W-1:0] mix_q;
    logic              mix_q_valid;

    logic              clr_start;
    logic              clr_busy;

    modport slave (
        input  host_req, host_we, host_bank, host_id, host_a, host_d,
        output host_ack, host_q, host_q_valid,
        input  mix_req, mix_bank, mix_id, mix_a,
        output mix_ack, mix_q, mix_q_valid,
        input  clr_start,
        output clr_busy
    );

    modport master (
        output host_req, host_we, host_bank, host_id, host_a, host_d,
        input  host_ack, host_q, host_q_valid,
        output mix_req, mix_bank, mix_id, mix_a,
        input  mix_ack, mix_q, mix_q_valid,
        output clr_start,
        input  clr_busy
    );
endinterface

// File: rtl/wts_sram_arb_pick.sv
// Combinational grant selection: mixer has priority; with WTS_ARB_HOST_GUARD_EN
// the host wins a contested cycle once the mixer streak reaches GUARD_LIMIT.
module wts_sram_arb_pick
    import wts_arb_pkg::*;
#(
    parameter int GUARD_LIMIT = GUARD_LIMIT_DEFAULT
) (
    input  logic               enable,
    input  logic               host_req,
    input  logic               mix_req,
`ifdef WTS_ARB_HOST_GUARD_EN
    input  logic [GUARD_W-1:0] guard_cnt,
`endif
    output logic               host_grant,
    output logic               mix_grant
);
    logic host_turn;

`ifdef WTS_ARB_HOST_GUARD_EN
    assign host_turn = (guard_cnt >= GUARD_W'(GUARD_LIMIT));
`else
    logic unused_limit;
    assign host_turn    = 1'b0;
    assign unused_limit = (GUARD_LIMIT != 0);
`endif

    always_comb begin
        host_grant = 1'b0;
        mix_grant  = 1'b0;
        if (enable) begin
            if (mix_req && !(host_req && host_turn)) begin
                mix_grant = 1'b1;
            end else if (host_req) begin
                host_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wts_sram_arbiter.sv
// Two-requester arbiter in front of a synchronous wavetable SRAM, with a clear-all sweep.
// Optional host starvation guard enabled by defining WTS_ARB_HOST_GUARD_EN.
module wts_sram_arbiter
    import wts_arb_pkg::*;
#(
    parameter int GUARD_LIMIT = GUARD_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    wts_sram_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    output logic              ram_oe,
    input  logic [DATA_W-1:0] ram_q
);
    arb_state_t        state;
    arb_state_t        state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;
    logic              arb_open;
    logic              host_grant;
    logic              mix_grant;
    logic [ADDR_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_d;
    logic              cmd_we;
    logic              cmd_oe;
    req_tag_t          cmd_tag;
    req_tag_t          s1_tag;
    req_tag_t          s2_tag;
`ifdef WTS_ARB_HOST_GUARD_EN
    logic [GUARD_W-1:0] guard_cnt;
`endif

    assign clr_last     = (clr_addr == ADDR_W'(RAM_SIZE - 1));
    assign arb_open     = (state == IDLE) && !bus.clr_start;
    assign bus.clr_busy = (state == CLEAR);
    assign bus.host_ack = host_grant;
    assign bus.mix_ack  = mix_grant;

    wts_sram_arb_pick #(
        .GUARD_LIMIT (GUARD_LIMIT)
    ) u_pick (
        .enable     (arb_open),
        .host_req   (bus.host_req),
        .mix_req    (bus.mix_req),
`ifdef WTS_ARB_HOST_GUARD_EN
        .guard_cnt  (guard_cnt),
`endif
        .host_grant (host_grant),
        .mix_grant  (mix_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.clr_start) state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sweep address naturally wraps back to zero after the last word
    always_ff @(posedge clk) begin
        if (reset || state != CLEAR) begin
            clr_addr <= '0;
        end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

`ifdef WTS_ARB_HOST_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset || !bus.host_req || host_grant) begin
            guard_cnt <= '0;
        end else if (mix_grant) begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
        end
    end
`endif

    always_comb begin
        cmd_a   = '0;
        cmd_d   = '0;
        cmd_we  = 1'b0;
        cmd_oe  = 1'b0;
        cmd_tag = NONE;
        if (state == CLEAR) begin
            cmd_a  = clr_addr;
            cmd_we = 1'b1;
        end else if (mix_grant) begin
            cmd_a   = ram_addr(bus.mix_bank, bus.mix_id, bus.mix_a);
            cmd_oe  = 1'b1;
            cmd_tag = MIX;
        end else if (host_grant) begin
            cmd_a   = ram_addr(bus.host_bank, bus.host_id, bus.host_a);
            cmd_we  = bus.host_we;
            cmd_oe  = !bus.host_we;
            cmd_d   = bus.host_we ? bus.host_d : '0;
            cmd_tag = bus.host_we ? NONE : HOST;
        end
    end

    // Tag follows the read through RAM latency so data returns to whoever asked
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_a            <= '0;
            ram_d            <= '0;
            ram_we           <= 1'b0;
            ram_oe           <= 1'b0;
            s1_tag           <= NONE;
            s2_tag           <= NONE;
            bus.host_q       <= '0;
            bus.host_q_valid <= 1'b0;
            bus.mix_q        <= '0;
            bus.mix_q_valid  <= 1'b0;
        end else begin
            ram_a            <= cmd_a;
            ram_d            <= cmd_d;
            ram_we           <= cmd_we;
            ram_oe           <= cmd_oe;
            s1_tag           <= cmd_tag;
            s2_tag           <= s1_tag;
            bus.host_q_valid <= (s2_tag == HOST);
            bus.mix_q_valid  <= (s2_tag == MIX);
            if (s2_tag == HOST) bus.host_q <= ram_q;
            if (s2_tag == MIX)  bus.mix_q  <= ram_q;
        end
    end
endmodule

// File: tb/tb_wts_sram_arbiter.sv
// Self-checking bench for wts_sram_arbiter: cycle-level reference model plus directed
// literal checks and randomized traffic. Guard expectations follow WTS_ARB_HOST_GUARD_EN.
module tb_wts_sram_arbiter;
    import wts_arb_pkg::*;

    localparam int GUARD_LIMIT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic              ram_we;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] ram_mem [RAM_SIZE];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    wts_sram_arbiter_if bus ();

    wts_sram_arbiter #(
        .GUARD_LIMIT (GUARD_LIMIT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .ram_a  (ram_a),
        .ram_d  (ram_d),
        .ram_we (ram_we),
        .ram_oe (ram_oe),
        .ram_q  (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_d;
        if (ram_oe) ram_q <= ram_mem[ram_a];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected RAM command per cycle and expected read returns, in 4-slot rings
    logic       e_we  [4];
    logic       e_oe  [4];
    logic [10:0] e_a  [4];
    logic [7:0] e_d   [4];
    logic       e_hqv [4];
    logic       e_mqv [4];
    logic [7:0] e_hqd [4];
    logic [7:0] e_mqd [4];
    logic [7:0] e_hq, e_mq;
    logic [7:0] m_mem [RAM_SIZE];
    bit         m_clear;
    int         m_clr;
    int         m_guard;
    bit         live = 0;

    task automatic modelStep();
        int sk, s1, s3;
        bit hg, mg, turn;
        logic [10:0] a;
        sk = cyc % 4;
        s1 = (cyc + 1) % 4;
        s3 = (cyc + 3) % 4;
        if (live) begin
            if (e_hqv[sk]) e_hq = e_hqd[sk];
            if (e_mqv[sk]) e_mq = e_mqd[sk];
            checkOutput("ram_we", ram_we, e_we[sk]);
            checkOutput("ram_oe", ram_oe, e_oe[sk]);
            if (e_we[sk] || e_oe[sk]) checkOutput("ram_a", ram_a, e_a[sk]);
            if (e_we[sk]) checkOutput("ram_d", ram_d, e_d[sk]);
            checkOutput("host_q_valid", bus.host_q_valid, e_hqv[sk]);
            checkOutput("host_q", bus.host_q, e_hq);
            checkOutput("mix_q_valid", bus.mix_q_valid, e_mqv[sk]);
            checkOutput("mix_q", bus.mix_q, e_mq);
            checkOutput("clr_busy", bus.clr_busy, m_clear);
        end
        if (reset) begin
            if (!live) for (int i = 0; i < RAM_SIZE; i++) m_mem[i] = 8'h00;
            for (int i = 0; i < 4; i++) begin
                e_we[i] = 0; e_oe[i] = 0; e_a[i] = 0; e_d[i] = 0;
                e_hqv[i] = 0; e_mqv[i] = 0; e_hqd[i] = 0; e_mqd[i] = 0;
            end
            e_hq = 0; e_mq = 0;
            m_clear = 0; m_clr = 0; m_guard = 0;
            live = 1;
        end else begin
            hg = 0; mg = 0; turn = 0;
`ifdef WTS_ARB_HOST_GUARD_EN
            turn = (m_guard >= GUARD_LIMIT);
`endif
            if (!m_clear && !bus.clr_start) begin
                if (bus.mix_req && !(bus.host_req && turn)) mg = 1;
                else if (bus.host_req) hg = 1;
            end
            checkOutput("host_ack", bus.host_ack, hg);
            checkOutput("mix_ack", bus.mix_ack, mg);
            e_we[s1] = 0; e_oe[s1] = 0; e_a[s1] = 0; e_d[s1] = 0;
            e_hqv[s3] = 0; e_mqv[s3] = 0;
            if (m_clear) begin
                e_we[s1] = 1;
                e_a[s1]  = 11'(m_clr);
                m_mem[m_clr] = 8'h00;
                if (m_clr == RAM_SIZE - 1) m_clear = 0;
                m_clr = (m_clr + 1) % RAM_SIZE;
            end else if (bus.clr_start) begin
                m_clear = 1;
                m_clr   = 0;
            end else if (mg) begin
                a = {bus.mix_bank, bus.mix_id, bus.mix_a};
                e_oe[s1] = 1; e_a[s1] = a;
                e_mqv[s3] = 1; e_mqd[s3] = m_mem[a];
            end else if (hg) begin
                a = {bus.host_bank, bus.host_id, bus.host_a};
                e_a[s1] = a;
                if (bus.host_we) begin
                    e_we[s1] = 1; e_d[s1] = bus.host_d;
                    m_mem[a] = bus.host_d;
                end else begin
                    e_oe[s1] = 1;
                    e_hqv[s3] = 1; e_hqd[s3] = m_mem[a];
                end
            end
            if (!bus.host_req || hg) m_guard = 0;
            else if (mg) m_guard++;
        end
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        modelStep();
    end

    task automatic applyStimulus(input logic rst, input logic clr,
                                 input logic hreq, input logic hwe, input logic [10:0] haddr,
                                 input logic [7:0] hd, input logic mreq, input logic [10:0] maddr);
        @(posedge clk);
        #2;
        reset         = rst;
        bus.clr_start = clr;
        bus.host_req  = hreq;
        bus.host_we   = hwe;
        {bus.host_bank, bus.host_id, bus.host_a} = haddr;
        bus.host_d    = hd;
        bus.mix_req   = mreq;
        {bus.mix_bank, bus.mix_id, bus.mix_a} = maddr;
    endtask

    task automatic idleStep();
        applyStimulus(0, 0, 0, 0, 11'h0, 8'h00, 0, 11'h0);
    endtask

    // Starts a clear with both requesters reading and measures the sweep
    task automatic doClear();
        int busy_n, we_n, ack_n, nz_n;
        busy_n = 0; we_n = 0; ack_n = 0; nz_n = 0;
        applyStimulus(0, 1, 1, 0, 11'h105, 8'h00, 1, 11'h7FF);
        @(negedge clk);
        checkOutput("clr_start_acks", {bus.host_ack, bus.mix_ack}, 2'b00);
        applyStimulus(0, 0, 1, 0, 11'h105, 8'h00, 1, 11'h7FF);
        for (int i = 0; i < 2100; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            if (bus.clr_busy) begin
                busy_n++;
                if (bus.host_ack || bus.mix_ack) ack_n++;
            end
            if (ram_we) begin
                we_n++;
                if (ram_d != 8'h00) nz_n++;
            end
            if (!bus.clr_busy) break;
        end
        checkOutput("clr_busy_cycles", busy_n, 2048);
        checkOutput("clr_write_count", we_n, 2048);
        checkOutput("clr_acks", ack_n, 0);
        checkOutput("clr_nonzero_data", nz_n, 0);
        idleStep();
        repeat (4) idleStep();
    endtask

    logic [7:0] mv_log;
    logic [7:0] mq_log [8];
    logic [7:0] hpat, mpat;
    logic       hreq, hwe, mreq, rst, clr, h_ack, m_ack;
    logic [10:0] haddr, maddr;
    logic [7:0] hd;
    bit         seen;

    initial begin
        reset = 1'b1;
        bus.clr_start = 0; bus.host_req = 0; bus.host_we = 0; bus.host_bank = 0;
        bus.host_id = 0; bus.host_a = 0; bus.host_d = 0;
        bus.mix_req = 0; bus.mix_bank = 0; bus.mix_id = 0; bus.mix_a = 0;
        repeat (3) applyStimulus(1, 0, 0, 0, 11'h0, 8'h00, 0, 11'h0);
        idleStep();
        @(negedge clk);
        checkOutput("reset_ram_we", ram_we, 0);
        checkOutput("reset_ram_oe", ram_oe, 0);
        checkOutput("reset_ram_a", ram_a, 0);
        checkOutput("reset_ram_d", ram_d, 0);
        checkOutput("reset_host_q", bus.host_q, 0);
        checkOutput("reset_mix_q", bus.mix_q, 0);
        checkOutput("reset_qv", {bus.host_q_valid, bus.mix_q_valid}, 0);
        checkOutput("reset_clr_busy", bus.clr_busy, 0);

        $display("[TB] initial clear");
        doClear();

        $display("[TB] host write then read");
        applyStimulus(0, 0, 1, 1, 11'h105, 8'h5A, 0, 11'h0);
        @(negedge clk);
        checkOutput("wr_host_ack", bus.host_ack, 1);
        applyStimulus(0, 0, 1, 0, 11'h105, 8'h00, 0, 11'h0);
        @(negedge clk);
        checkOutput("wr_ram_we", ram_we, 1);
        checkOutput("wr_ram_a", ram_a, 11'h105);
        checkOutput("wr_ram_d", ram_d, 8'h5A);
        idleStep();
        @(negedge clk);
        checkOutput("rd_ram_oe", ram_oe, 1);
        checkOutput("rd_ram_a", ram_a, 11'h105);
        idleStep();
        @(negedge clk);
        checkOutput("rd_early_qv", bus.host_q_valid, 0);
        idleStep();
        @(negedge clk);
        checkOutput("rd_qv", bus.host_q_valid, 1);
        checkOutput("rd_q", bus.host_q, 8'h5A);
        idleStep();
        @(negedge clk);
        checkOutput("rd_qv_pulse", bus.host_q_valid, 0);
        checkOutput("rd_q_hold", bus.host_q, 8'h5A);

        $display("[TB] mixer back-to-back reads");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 11'(11'h580 + i), 8'(8'hA0 + i), 0, 11'h0);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) applyStimulus(0, 0, 0, 0, 11'h0, 8'h00, 1, 11'(11'h580 + i));
            else idleStep();
            @(negedge clk);
            mv_log[i] = bus.mix_q_valid;
            mq_log[i] = bus.mix_q;
        end
        checkOutput("mix_qv_pattern", mv_log, 8'b0111_1000);
        for (int j = 0; j < 4; j++) checkOutput("mix_q_order", mq_log[3 + j], 8'(8'hA0 + j));

        $display("[TB] contested requests");
        idleStep();
        applyStimulus(0, 0, 1, 0, 11'h001, 8'h00, 1, 11'h002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hpat[i] = bus.host_ack;
            mpat[i] = bus.mix_ack;
        end
`ifdef WTS_ARB_HOST_GUARD_EN
        checkOutput("contest_mix_pattern", mpat, 8'b0111_0111);
        checkOutput("contest_host_pattern", hpat, 8'b1000_1000);
`else
        checkOutput("contest_mix_pattern", mpat, 8'b1111_1111);
        checkOutput("contest_host_pattern", hpat, 8'b0000_0000);
`endif
        repeat (5) idleStep();

        $display("[TB] clear with both requesting, then read back");
        doClear();
        applyStimulus(0, 0, 1, 0, 11'h105, 8'h00, 0, 11'h0);
        repeat (3) idleStep();
        @(negedge clk);
        checkOutput("post_clear_qv", bus.host_q_valid, 1);
        checkOutput("post_clear_q", bus.host_q, 8'h00);

        $display("[TB] reset drops in-flight read");
        idleStep();
        applyStimulus(0, 0, 1, 0, 11'h580, 8'h00, 0, 11'h0);
        @(negedge clk);
        checkOutput("pend_host_ack", bus.host_ack, 1);
        applyStimulus(1, 0, 0, 0, 11'h0, 8'h00, 0, 11'h0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            idleStep();
            @(negedge clk);
            if (bus.host_q_valid) seen = 1;
        end
        checkOutput("pend_read_qv_after_reset", seen, 0);

        $display("[TB] reset during clear");
        applyStimulus(0, 1, 0, 0, 11'h0, 8'h00, 0, 11'h0);
        idleStep();
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ram_we && ram_a == 11'd99) begin
                seen = 1;
                break;
            end
        end
        checkOutput("clr_addr99_seen", seen, 1);
        applyStimulus(1, 0, 0, 0, 11'h0, 8'h00, 0, 11'h0);
        @(negedge clk);
        checkOutput("abort_ram_a", ram_a, 11'd100);
        checkOutput("abort_busy_before", bus.clr_busy, 1);
        idleStep();
        @(negedge clk);
        checkOutput("abort_busy_after", bus.clr_busy, 0);
        checkOutput("abort_ram_we", ram_we, 0);
        checkOutput("abort_qv", {bus.host_q_valid, bus.mix_q_valid}, 0);
        repeat (3) idleStep();

        $display("[TB] random traffic");
        h_ack = 0; m_ack = 0;
        hreq = 0; hwe = 0; haddr = 0; hd = 0; mreq = 0; maddr = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 1499) == 0);
            if (!(hreq && !h_ack)) begin
                hreq  = ($urandom_range(0, 2) != 0);
                hwe   = 1'($urandom_range(0, 1));
                haddr = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
                hd    = 8'($urandom);
            end
            if (!(mreq && !m_ack)) begin
                mreq  = ($urandom_range(0, 1) != 0);
                maddr = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
            end
            applyStimulus(rst, clr, hreq, hwe, haddr, hd, mreq, maddr);
            @(negedge clk);
            h_ack = bus.host_ack || rst;
            m_ack = bus.mix_ack || rst;
        end
        repeat (6) idleStep();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("[TB] FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/wts_sram_arbiter.md
WTS_SRAM_ARBITER -- requirements
Module: wts_sram_arbiter

Interface
REQ-001 SHALL have parameter GUARD_LIMIT, default 3, max consecutive mixer grants while host pending (guard build only).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have host port: host_req in 1, host_we in 1, host_bank in 1, host_id in 3, host_a in 7, host_d in 8 (request, write enable, bank/wave/byte address, write data).
REQ-005 SHALL have host_ack out 1 (combinational grant), host_q out 8, host_q_valid out 1 (read data, one-cycle pulse).
REQ-006 SHALL have mixer port (read-only): mix_req in 1, mix_bank in 1, mix_id in 3, mix_a in 7, mix_ack out 1, mix_q out 8, mix_q_valid out 1.
REQ-007 SHALL have clr_start in 1 (clear-all pulse) and clr_busy out 1.
REQ-008 SHALL have RAM port: ram_a out 11 ({bank,id,a}), ram_d out 8, ram_we out 1, ram_oe out 1, ram_q in 8 (synchronous RAM, one-cycle read latency).

Function
REQ-009 SHALL complete a transfer in cycle N when req and ack are both high; req held with ack low SHALL wait, address/data stable.
REQ-010 SHALL grant at most one requester per cycle; mix_ack wins when both request (strict priority, non-guard build).
REQ-011 SHALL register the granted command: ram_a/ram_d/ram_we/ram_oe valid in cycle N+1; all ram controls low when no transfer in cycle N.
REQ-012 SHALL capture ram_q in cycle N+2 and present *_q with *_q_valid high for exactly cycle N+3 to the requester that read; writes produce no q_valid.
REQ-013 SHALL sustain one transfer per cycle back-to-back; a requester holding req after a transfer issues a new request.
REQ-014 SHALL use FSM states IDLE (arbitrate) and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after address 2047 written.
REQ-015 In CLEAR, SHALL write 0x00 to ram_a 0..2047 ascending, one per cycle, ram_we high; host_ack and mix_ack low; clr_busy high.
REQ-016 SHALL ignore clr_start while in CLEAR; reads in flight at CLEAR entry still deliver q_valid.
REQ-017 SHALL let clr_start take precedence over requests in the same cycle (no acks that cycle).
REQ-018 SHALL hold *_q at last value when *_q_valid low.

Reset
REQ-019 On reset SHALL go to IDLE, clear in-flight pipeline (no q_valid after reset), zero clear counter and guard counter.
REQ-020 Reset values: host_q_valid, mix_q_valid, clr_busy, ram_we, ram_oe = 0; ram_a, ram_d, host_q, mix_q = 0.
REQ-021 Reset mid-CLEAR SHALL abort the clear; clr_busy low from the next cycle.

Configuration
REQ-022 Macro WTS_ARB_HOST_GUARD_EN defined: SHALL count consecutive mixer grants while host_req high; at GUARD_LIMIT, next contested cycle grants host and counter resets to 0; counter also resets on any host grant or cycle without host_req.
REQ-023 Macro undefined: SHALL use strict mixer priority; guard counter and GUARD_LIMIT logic absent.

Structure
REQ-024 SHALL place in shared package wts_arb_pkg: address width 11, RAM size 2048, state enum (IDLE, CLEAR), requester tag enum (NONE, HOST, MIX), GUARD_LIMIT default.
REQ-025 SHALL put grant selection (priority plus guard) in one combinational sub-module wts_sram_arb_pick; FSM, pipeline and RAM drive stay in top.

Verification
REQ-026 Host write bank0/id2/a5=0x5A, then host read same -> ram_a=0x105 writes in N+1; host_q=0x5A, host_q_valid pulse in read's N+3.
REQ-027 mix_req and host_req held 8 cycles -> no guard: 8 mix acks, 0 host acks; guard, GUARD_LIMIT=3: pattern M,M,M,H repeating.
REQ-028 Alternating mixer reads to a=0..3 back-to-back -> 4 mix_q_valid pulses on consecutive cycles, data in order.
REQ-029 clr_start with both reqs high -> 2048 writes of 0x00, acks low, clr_busy high 2048 cycles; subsequent read returns 0x00.
REQ-030 reset at clear address 100 -> clr_busy low next cycle, ram_we low, no q_valid; pending host read issued before reset produces no q_valid.
